// File: rtl/wb_cpu_master_pkg.sv
// Shared definitions for the 6502-side Wishbone initiator: FSM encoding,
// default bus widths and the TIA register addresses used by benches and CPU glue.
package wb_cpu_master_pkg;

  localparam int WB_DATA_WIDTH_DEF = 8;
  localparam int WB_ADDR_WIDTH_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

  // TIA registers whose strobes have side effects or that are commonly polled
  localparam logic [6:0] TIA_WSYNC = 7'h02;
  localparam logic [6:0] TIA_HMOVE = 7'h2A;
  localparam logic [6:0] TIA_INPT4 = 7'h0C;

endpackage

// File: rtl/wb_cpu_master_timeout_ctr.sv
// WAIT-state watchdog for wb_cpu_master; only built when WB_TIMEOUT_EN is defined.
// Clears on load, counts WAIT cycles, flags expiry on the TIMEOUT_CYCLES-th one.
`ifdef WB_TIMEOUT_EN
module wb_cpu_master_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 16) ? $clog2(TIMEOUT_CYCLES) : 4;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (count_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q is 0 in the first WAIT cycle, so LAST marks the TIMEOUT_CYCLES-th one
  assign expire_o = count_i && (cnt_q == LAST);

endmodule
`endif

// File: rtl/wb_cpu_master.sv
// Single-transaction Wishbone initiator between the 6502 core and TIA/RIOT/RAM.
// Optional ack watchdog enabled by defining WB_TIMEOUT_EN.
module wb_cpu_master
  import wb_cpu_master_pkg::*;
#(
  parameter int WB_DATA_WIDTH  = WB_DATA_WIDTH_DEF,
  parameter int WB_ADDR_WIDTH  = WB_ADDR_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_i,
  input  logic                     req_we_i,
  input  logic [WB_ADDR_WIDTH-1:0] req_adr_i,
  input  logic [WB_DATA_WIDTH-1:0] req_dat_i,
  output logic                     req_rdy_o,
  output logic                     rsp_valid_o,
  output logic [WB_DATA_WIDTH-1:0] rsp_dat_o,
  output logic                     rsp_err_o,
  input  logic                     stall_i,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic                     ack_i,
  input  logic [WB_DATA_WIDTH-1:0] dat_i
);

  state_e                   state_q, state_d;
  logic                     run_q;
  logic                     cyc_q, cyc_d;
  logic                     stb_q, stb_d;
  logic                     we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [WB_DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic                     rsp_err_q, rsp_err_d;
  logic                     accept;
  logic                     expire;

  // run_q keeps req_rdy_o low while reset is asserted
  assign req_rdy_o = run_q && (state_q == ST_IDLE) && !stall_i;
  assign accept    = req_i && req_rdy_o;

`ifdef WB_TIMEOUT_EN
  wb_cpu_master_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  ((state_q == ST_STROBE) && !ack_i),
    .count_i (state_q == ST_WAIT),
    .expire_o(expire)
  );
`else
  // Without the watchdog an abort can never be raised; WAIT lasts until ack_i
  assign expire = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = 1'b0;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = 1'b0;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_STROBE;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = req_we_i;
          adr_d   = req_adr_i;
          dat_d   = req_dat_i;
        end
      end
      ST_STROBE, ST_WAIT: begin
        // ack beats a simultaneous expiry
        if (ack_i) begin
          state_d     = ST_IDLE;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          if (!we_q) begin
            rsp_dat_d = dat_i;
          end
        end else if (expire) begin
          state_d     = ST_IDLE;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = '0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      run_q       <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cyc_o       = cyc_q;
  assign stb_o       = stb_q;
  assign we_o        = we_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_cpu_master.sv
// Bench for wb_cpu_master: transaction-timestamp model checked every cycle,
// directed scenarios plus random traffic. Timeout cases run when WB_TIMEOUT_EN is defined.
module tb_wb_cpu_master;
  import wb_cpu_master_pkg::*;

  localparam int AW = 7;
  localparam int DW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0, req_we = 1'b0, stall = 1'b0, ack = 1'b0;
  logic [AW-1:0] req_adr = '0;
  logic [DW-1:0] req_dat = '0, dat_i = '0;
  logic          req_rdy, rsp_valid, rsp_err, cyc, stb, we;
  logic [DW-1:0] rsp_dat, dat_o;
  logic [AW-1:0] adr;

  always #5 clk = ~clk;

  wb_cpu_master #(
    .WB_DATA_WIDTH (DW),
    .WB_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .req_we_i   (req_we),
    .req_adr_i  (req_adr),
    .req_dat_i  (req_dat),
    .req_rdy_o  (req_rdy),
    .rsp_valid_o(rsp_valid),
    .rsp_dat_o  (rsp_dat),
    .rsp_err_o  (rsp_err),
    .stall_i    (stall),
    .cyc_o      (cyc),
    .stb_o      (stb),
    .we_o       (we),
    .adr_o      (adr),
    .dat_o      (dat_o),
    .ack_i      (ack),
    .dat_i      (dat_i)
  );

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  // Model: one transaction described by its accept cycle and its end (ack or abort) cycle
  int            acc_c = -100, end_c = -100;
  bit            end_err = 1'b0;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_adr = '0;
  logic [DW-1:0] m_dat = '0, m_rsp = '0, m_cap = '0;

  // Stimulus knobs, applied to the DUT at the next falling edge
  bit            req_v = 1'b0, we_v = 1'b0, stall_v = 1'b0;
  logic [AW-1:0] adr_v = '0;
  logic [DW-1:0] wd_v = '0;
  int            next_delay = 1;   // ack this many cycles after the strobe; <0 = never
  int            force_rd = -1;
  bit            stray_en = 1'b0, force_ack = 1'b0;

  // Observations of the DUT
  bit            dut_acc = 1'b0, dut_rsp = 1'b0;
  int            dut_acc_c = -1, dut_rsp_c = -1, strobes = 0;
  logic [AW-1:0] seen_adr = '0;
  logic          seen_we = 1'b0;
  logic [DW-1:0] seen_dat = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc_n, act, exp);
    end
  endtask

  task automatic zero_checks(input string tag);
    chk({tag, "_req_rdy"}, req_rdy, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_rsp_dat"}, rsp_dat, 0);
    chk({tag, "_cyc"}, cyc, 0);
    chk({tag, "_stb"}, stb, 0);
    chk({tag, "_we"}, we, 0);
    chk({tag, "_adr"}, adr, 0);
    chk({tag, "_dat_o"}, dat_o, 0);
  endtask

  task automatic model_reset();
    acc_c   = -100;
    end_c   = -100;
    end_err = 1'b0;
    m_we    = 1'b0;
    m_adr   = '0;
    m_dat   = '0;
    m_rsp   = '0;
  endtask

  // One clock cycle: drive inputs, predict, compare every output
  task automatic step();
    bit busy, rdy_e, ack_end;
    @(negedge clk);
    cyc_n++;
    req     = req_v;
    req_we  = we_v;
    req_adr = adr_v;
    req_dat = wd_v;
    stall   = stall_v;
    busy    = (cyc_n > acc_c) && (cyc_n <= end_c);
    rdy_e   = !busy && !stall_v;
    ack_end = (cyc_n == end_c) && !end_err;
    dat_i   = DW'($urandom);
    if (ack_end && force_rd >= 0) dat_i = DW'(force_rd);
    if (ack_end) m_cap = dat_i;
    ack = ack_end || (!busy && (force_ack || (stray_en && $urandom_range(0, 3) == 0)));
    if (cyc_n == end_c + 1) m_rsp = end_err ? '0 : (m_we ? m_rsp : m_cap);
    #1;
    chk("req_rdy", req_rdy, rdy_e);
    chk("cyc", cyc, busy);
    chk("stb", stb, cyc_n == acc_c + 1);
    chk("rsp_valid", rsp_valid, cyc_n == end_c + 1);
    chk("we", we, m_we);
    chk("adr", adr, m_adr);
    chk("dat_o", dat_o, m_dat);
    chk("rsp_dat", rsp_dat, m_rsp);
    if (cyc_n == end_c + 1) chk("rsp_err", rsp_err, end_err);
    dut_acc = req && (req_rdy === 1'b1);
    if (dut_acc) dut_acc_c = cyc_n;
    dut_rsp = (rsp_valid === 1'b1);
    if (dut_rsp) dut_rsp_c = cyc_n;
    if (stb === 1'b1) begin
      strobes++;
      seen_adr = adr;
      seen_we  = we;
      seen_dat = dat_o;
    end
    if (req_v && rdy_e) begin
      acc_c = cyc_n;
`ifdef WB_TIMEOUT_EN
      end_err = (next_delay < 0) || (next_delay > TO);
`else
      end_err = 1'b0;
`endif
      end_c = cyc_n + 1 + (end_err ? TO : next_delay);
      m_we  = we_v;
      m_adr = adr_v;
      m_dat = wd_v;
    end
  endtask

  task automatic run_txn(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int dly, output int lat);
    int n;
    req_v = 1'b1; we_v = w; adr_v = a; wd_v = d; next_delay = dly;
    n = 0;
    do begin step(); n++; end while (!dut_acc && n < 100);
    req_v = 1'b0;
    chk("txn_accepted", dut_acc, 1);
    n = 0;
    do begin step(); n++; end while (!dut_rsp && n < 100);
    chk("txn_responded", dut_rsp, 1);
    lat = dut_rsp_c - dut_acc_c;
    $display("txn we=%0d adr=%02h dat=%02h delay=%0d latency=%0d rsp_dat=%02h err=%0d",
             w, a, d, dly, lat, rsp_dat, rsp_err);
  endtask

  initial begin
    int lat, s0, cnt, first, second;
    #1 zero_checks("por");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();

    // Write 0x09/0x84, registered ack
    s0 = strobes;
    run_txn(1'b1, 7'h09, 8'h84, 1, lat);
    chk("wr_latency", lat, 3);
    chk("wr_strobes", strobes - s0, 1);
    chk("wr_adr", seen_adr, 7'h09);
    chk("wr_we", seen_we, 1);
    chk("wr_dat", seen_dat, 8'h84);

    // Read INPT4 returning 0x80: combinational ack, then registered ack
    force_rd = 8'h80;
    run_txn(1'b0, TIA_INPT4, 8'h00, 0, lat);
    chk("rd_comb_latency", lat, 2);
    chk("rd_comb_data", rsp_dat, 8'h80);
    chk("rd_comb_err", rsp_err, 0);
    run_txn(1'b0, TIA_INPT4, 8'h00, 1, lat);
    chk("rd_reg_latency", lat, 3);
    chk("rd_reg_data", rsp_dat, 8'h80);
    force_rd = -1;

    // WSYNC then 40 cycles of stall with the next request held
    run_txn(1'b1, TIA_WSYNC, 8'h00, 1, lat);
    stall_v = 1'b1; req_v = 1'b1; we_v = 1'b0; adr_v = TIA_INPT4; next_delay = 1;
    cnt = 0;
    repeat (40) begin
      step();
      if (req_rdy === 1'b0) cnt++;
    end
    chk("wsync_rdy_low", cnt, 40);
    stall_v = 1'b0;
    step();
    chk("wsync_accept_at_release", dut_acc, 1);
    req_v = 1'b0;
    repeat (3) step();
    $display("txn wsync stall=40 rdy_low=%0d", cnt);

    // Back-to-back writes to HMOVE and 0x2B
    s0 = strobes; first = -1; second = -1; cnt = 0;
    req_v = 1'b1; we_v = 1'b1; adr_v = TIA_HMOVE; wd_v = 8'h00; next_delay = 1;
    for (int i = 0; i < 20 && second < 0; i++) begin
      step();
      if (first >= 0 && cyc === 1'b0) cnt++;
      if (dut_acc) begin
        if (first < 0) begin
          first = cyc_n;
          adr_v = 7'h2B;
        end else begin
          second = cyc_n;
        end
      end
    end
    req_v = 1'b0;
    repeat (3) step();
    chk("b2b_gap", second - first, 3);
    chk("b2b_strobes", strobes - s0, 2);
    chk("b2b_cyc_low_between", cnt, 1);
    chk("b2b_last_adr", seen_adr, 7'h2B);
    $display("txn back-to-back first=%0d second=%0d", first, second);

    // Reset while waiting for a slow ack
    req_v = 1'b1; we_v = 1'b1; adr_v = 7'h11; wd_v = 8'h5A; next_delay = 12;
    cnt = 0;
    do begin step(); cnt++; end while (!dut_acc && cnt < 20);
    req_v = 1'b0;
    repeat (3) step();
    chk("rst_wait_cyc", cyc, 1);
    #2 rst_n = 1'b0;
    #1 zero_checks("rst_wait");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    cnt = dut_rsp;
    repeat (3) begin step(); cnt += dut_rsp; end
    chk("rst_stray_ack_no_rsp", cnt, 0);
    $display("txn reset-in-wait stray_ack_rsps=%0d", cnt);

`ifdef WB_TIMEOUT_EN
    force_rd = 8'h3C;
    run_txn(1'b0, TIA_INPT4, 8'h00, TO, lat);
    chk("to_ack_last_latency", lat, 17);
    chk("to_ack_last_err", rsp_err, 0);
    chk("to_ack_last_data", rsp_dat, 8'h3C);
    force_rd = -1;
    run_txn(1'b0, TIA_INPT4, 8'h00, -1, lat);
    chk("to_abort_latency", lat, 17);
    chk("to_abort_err", rsp_err, 1);
    chk("to_abort_data", rsp_dat, 0);
`endif

    // Random traffic with stalls and stray acks
    stray_en = 1'b1;
    repeat (500) begin
      req_v   = ($urandom_range(0, 2) != 0);
      we_v    = 1'($urandom_range(0, 1));
      adr_v   = AW'($urandom);
      wd_v    = DW'($urandom);
      stall_v = ($urandom_range(0, 7) == 0);
`ifdef WB_TIMEOUT_EN
      next_delay = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TO));
`else
      next_delay = ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 30))
                                               : int'($urandom_range(0, 4));
`endif
      step();
      if (dut_acc) $display("txn rand accept cycle=%0d we=%0d adr=%02h delay=%0d",
                            cyc_n, we_v, adr_v, next_delay);
    end
    req_v = 1'b0;
    stall_v = 1'b0;
    repeat (40) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc_n);
    $fatal(1, "simulation did not finish");
  end

endmodule

// File: doc/wb_cpu_master.md
Name: wb_cpu_master

Overview:
Wishbone initiator that turns 6502-side bus requests into single transactions on the peripheral Wishbone bus (TIA, RIOT, RAM responders).
- CPU core presents one request at a time over a valid/ready handshake. Block drives the strobe, waits for ack, then returns read data or write completion.
- Honours the TIA stall line (WSYNC): no new request is accepted while stall is high.

Parameters:
- WB_DATA_WIDTH, 8, data bus width.
- WB_ADDR_WIDTH, 7, address bus width.
- TIMEOUT_CYCLES, 15, cycles to wait for ack before abort (used only with WB_TIMEOUT_EN).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  CPU request valid.
- req_we_i  in  1  1 = write, 0 = read.
- req_adr_i  in  WB_ADDR_WIDTH  request address.
- req_dat_i  in  WB_DATA_WIDTH  write data.
- req_rdy_o  out  1  request accepted this cycle when req_i is also high.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_dat_o  out  WB_DATA_WIDTH  read data, valid with rsp_valid_o.
- rsp_err_o  out  1  timeout abort flag, valid with rsp_valid_o.
- stall_i  in  1  peripheral stall (TIA stall_cpu).
- cyc_o  out  1  Wishbone cycle.
- stb_o  out  1  Wishbone strobe.
- we_o  out  1  Wishbone write enable.
- adr_o  out  WB_ADDR_WIDTH  Wishbone address.
- dat_o  out  WB_DATA_WIDTH  Wishbone write data.
- ack_i  in  1  Wishbone acknowledge.
- dat_i  in  WB_DATA_WIDTH  Wishbone read data.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0: req_rdy_o, rsp_valid_o, rsp_err_o, cyc_o, stb_o, we_o, adr_o, dat_o, rsp_dat_o. Any in-flight transaction is dropped with no response.
- req_rdy_o = (state == IDLE) && !stall_i, registered-state based. Acceptance occurs on req_i && req_rdy_o; req_adr_i, req_dat_i and req_we_i are latched.
- States:
  - IDLE --accept--> STROBE.
  - STROBE: cyc_o=1, stb_o=1 for exactly one cycle. Strobe is a single pulse because responders act on every strobed cycle; a held stb would double-execute strobes such as HMOVE or WSYNC.
    - ack_i in STROBE (combinational responder) completes the transaction -> IDLE.
    - Otherwise -> WAIT.
  - WAIT: cyc_o=1, stb_o=0, adr_o/we_o/dat_o held stable. ack_i -> IDLE.
- Completion: the cycle after ack_i is sampled, rsp_valid_o=1 for one cycle.
  - Read: rsp_dat_o = dat_i captured at ack.
  - Write: rsp_dat_o holds its previous value.
  - rsp_err_o = 0.
  - cyc_o drops in the same cycle rsp_valid_o rises.
- Latency with a registered-ack responder:
  - accept at cycle N;
  - stb_o high at N+1;
  - ack_i at N+2;
  - rsp_valid_o and req_rdy_o at N+3.
  - Back-to-back accept at N+3 is legal.
- ack_i in IDLE is ignored and has no side effects.
- stall_i gates acceptance only: a transaction already in STROBE/WAIT completes normally. A stall arriving in the same cycle as req_i blocks that acceptance.
- req_i deasserting while not ready: no effect, no buffering. Requests are not queued; depth is one.
- Outputs adr_o/dat_o/we_o are registered and change only on acceptance.

Optional Feature:
- WB_TIMEOUT_EN defined:
  - 4-bit+ counter clears on entering WAIT and increments per WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without ack_i: cyc_o drops, then rsp_valid_o=1, rsp_err_o=1, rsp_dat_o=0, state IDLE.
  - An ack_i arriving in the same cycle as expiry wins and is a normal completion.
  - A late ack_i after abort falls in IDLE and is ignored.
- Undefined: WAIT persists indefinitely; rsp_err_o is tied 0; no counter logic is present.

Decomposition:
- Shared package/include wb_defs: state encoding localparams (ST_IDLE, ST_STROBE, ST_WAIT), default WB_DATA_WIDTH/WB_ADDR_WIDTH.
- TIA register address localparams (WSYNC=0x02, HMOVE=0x2A, INPT4=0x0C) live there too, for benches and the CPU glue.
- One natural sub-module, wb_timeout_ctr: load/count/expire, instantiated only under WB_TIMEOUT_EN.

Test Plan:
- Write adr 0x09 data 0x84, registered-ack responder -> stb_o high exactly 1 cycle, adr_o=0x09, dat_o=0x84, we_o=1; rsp_valid_o at accept+3; responder sees exactly one write.
- Read adr 0x0C, responder returns 0x80 -> rsp_valid_o pulse with rsp_dat_o=0x80, rsp_err_o=0; a combinational-ack responder gives rsp at accept+2.
- Write 0x02 (WSYNC), responder raises stall_i for 40 cycles, req_i held -> req_rdy_o=0 for all 40 cycles; second request accepted the first cycle stall_i is low.
- Back-to-back writes to 0x2A then 0x2B -> two separate single-cycle strobes, no double strobe, cyc_o low for exactly the rsp cycle between them.
- rst_ni pulsed low while in WAIT -> all outputs 0 immediately (async); no rsp_valid_o; a stray ack_i after release is ignored.
- WB_TIMEOUT_EN, TIMEOUT_CYCLES=15, no ack -> rsp_valid_o with rsp_err_o=1, rsp_dat_o=0 after 15 WAIT cycles; ack on cycle 15 instead -> normal completion, rsp_err_o=0.
